rpn_sequenciador_entrada: RTL

//  Front-end sequencer of the 8-bit RPN ALU; sits between the ENTER key/switches and the 2-bit step counter.

---
 rtl/rpn_sequenciador_entrada_if.sv | 35 +++
 rtl/rpn_sequenciador_entrada.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rpn_sequenciador_entrada_if.sv
// Bundle between the RPN input sequencer and its surroundings:
// ENTER key, switches, step counter and ALU handshake.
interface rpn_sequenciador_entrada_if #(
   parameter int WIDTH     = 8,
   parameter int OPC_WIDTH = 3
);
   logic                 botao;
   logic [WIDTH-1:0]     chaves;
   logic [1:0]           passo;
   logic                 avanca;
   logic [WIDTH-1:0]     operando_a;
   logic [WIDTH-1:0]     operando_b;
   logic [OPC_WIDTH-1:0] opcode;
   logic                 ula_start;
   logic                 ula_done;
   logic [WIDTH-1:0]     ula_result;
   logic [WIDTH-1:0]     resultado;
   logic                 result_valid;
   logic                 ocupado;
   logic                 erro;

   // Sequencer side
   modport slave (
      input  botao, chaves, passo, ula_done, ula_result,
      output avanca, operando_a, operando_b, opcode, ula_start,
             resultado, result_valid, ocupado, erro
   );

   // Board / counter / ALU side
   modport master (
      output botao, chaves, passo, ula_done, ula_result,
      input  avanca, operando_a, operando_b, opcode, ula_start,
             resultado, result_valid, ocupado, erro
   );
endinterface

// File: rtl/rpn_sequenciador_entrada.sv
// ENTER-key sequencer of the 8-bit RPN ALU: captures A, B, opcode, then runs the ALU.
// Optional macro RPN_RESULT_CHAIN_EN: at step 0, reload operand A from the last valid result.
module rpn_sequenciador_entrada #(
   parameter int WIDTH       = 8,
   parameter int OPC_WIDTH   = 3,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   rpn_sequenciador_entrada_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_STEP = 2'd1,
      EXEC      = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_prev_q;
   logic                   press;
   logic [WIDTH-1:0]       a_q, a_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic [OPC_WIDTH-1:0]   opc_q, opc_d;
   logic [WIDTH-1:0]       res_q, res_d;
   logic                   rv_q, rv_d;
   logic                   erro_q, erro_d;
   logic                   avanca_q, avanca_d;
   logic                   start_q, start_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [WIDTH-1:0]       a_src;

   // Key synchronizer plus rising-edge detect: a held key yields a single press.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q     <= '0;
         key_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.botao};
         key_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign press = sync_q[SYNC_STAGES-1] & ~key_prev_q;

`ifdef RPN_RESULT_CHAIN_EN
   assign a_src = rv_q ? res_q : bus.chaves;
`else
   assign a_src = bus.chaves;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         opc_q    <= '0;
         res_q    <= '0;
         rv_q     <= 1'b0;
         erro_q   <= 1'b0;
         avanca_q <= 1'b0;
         start_q  <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opc_q    <= opc_d;
         res_q    <= res_d;
         rv_q     <= rv_d;
         erro_q   <= erro_d;
         avanca_q <= avanca_d;
         start_q  <= start_d;
         timer_q  <= timer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      opc_d    = opc_q;
      res_d    = res_q;
      rv_d     = rv_q;
      erro_d   = erro_q;
      avanca_d = 1'b0;
      start_d  = 1'b0;
      timer_d  = timer_q;
      case (state_q)
         IDLE: begin
            if (bus.passo == 2'd3) begin
               start_d = 1'b1;
               rv_d    = 1'b0;
               timer_d = '0;
               state_d = EXEC;
            end else if (press) begin
               avanca_d = 1'b1;
               state_d  = WAIT_STEP;
               case (bus.passo)
                  2'd0:    a_d   = a_src;
                  2'd1:    b_d   = bus.chaves;
                  default: opc_d = bus.chaves[OPC_WIDTH-1:0];
               endcase
            end
         end
         WAIT_STEP: state_d = IDLE;
         EXEC: begin
            if (timer_q != TW'(TIMEOUT)) begin
               timer_d = timer_q + 1'b1;
            end
            // The done strobe is ignored while our own start pulse is still on the wire.
            if (bus.ula_done && !start_q) begin
               res_d    = bus.ula_result;
               rv_d     = 1'b1;
               avanca_d = 1'b1;
               state_d  = WAIT_STEP;
            end else if (timer_q == TW'(TIMEOUT)) begin
               erro_d   = 1'b1;
               avanca_d = 1'b1;
               state_d  = WAIT_STEP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.avanca       = avanca_q;
   assign bus.operando_a   = a_q;
   assign bus.operando_b   = b_q;
   assign bus.opcode       = opc_q;
   assign bus.ula_start    = start_q;
   assign bus.resultado    = res_q;
   assign bus.result_valid = rv_q;
   assign bus.ocupado      = (state_q != IDLE);
   assign bus.erro         = erro_q;
endmodule
